// File: rtl/ball_pkg.sv
// ---------------------------------------------------------------------------
// ball_pkg
// Shared types and constants for the ball motion controller.
//   state_t    : per-frame sequencer states
//   KEY_*      : USB HID keycodes the controller reacts to
//   BALL_*     : default screen bounds, centre, step and radius limits
//   axis_t     : position/motion pair for one axis
//   boundAxis  : edge clamp/bounce rule for one axis
// ---------------------------------------------------------------------------
package ball_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    MOVE,
    BOUND,
    DONE
  } state_t;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_PLUS  = 8'h2E;
  localparam logic [7:0] KEY_MINUS = 8'h2D;

  localparam int BALL_X_MIN    = 0;
  localparam int BALL_X_MAX    = 639;
  localparam int BALL_Y_MIN    = 0;
  localparam int BALL_Y_MAX    = 479;
  localparam int BALL_X_CENTER = 320;
  localparam int BALL_Y_CENTER = 240;
  localparam int BALL_STEP     = 1;
  localparam int BALL_SIZE_DEF = 4;
  localparam int BALL_SIZE_MIN = 2;
  localparam int BALL_SIZE_MAX = 32;

  typedef struct packed {
    logic signed [10:0] pos;
    logic signed [10:0] mot;
  } axis_t;

  // Far edge wins if the ball somehow touches both; the ball is then pushed
  // inside and its motion on this axis points away from the edge it hit.
  function automatic axis_t boundAxis(input logic signed [10:0] pos,
                                      input logic signed [10:0] size,
                                      input logic signed [10:0] mot,
                                      input logic signed [10:0] lo,
                                      input logic signed [10:0] hi,
                                      input logic signed [10:0] step);
    axis_t res;
    res.pos = pos;
    res.mot = mot;
    if (pos + size >= hi) begin
      res.pos = hi - size;
      res.mot = -step;
    end else if (pos - size <= lo) begin
      res.pos = lo + size;
      res.mot = step;
    end
    return res;
  endfunction

endpackage

// File: rtl/ball_motion_ctrl_edge_sync.sv
// ---------------------------------------------------------------------------
// edge_sync
// Brings an asynchronous level (VGA vsync) into the Clk domain through two
// flops and emits a one-cycle pulse on each rising edge.
//   Clk      in  system clock
//   Reset_n  in  asynchronous active-low reset
//   i_async  in  asynchronous input level
//   o_rise   out one-cycle pulse, 2-3 Clk after the input rises
// ---------------------------------------------------------------------------
module edge_sync (
  input  logic Clk,
  input  logic Reset_n,
  input  logic i_async,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Two-flop synchroniser followed by a delay flop for edge detection.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/ball_motion_ctrl.sv
// ---------------------------------------------------------------------------
// ball_motion_ctrl
// Per-frame sequencer for the ball drawn by color_mapper. On each rising
// frame_clk it applies steering/size keys, moves the ball one step and
// clamps/bounces it at the screen edges.
//   Clk        in   system clock
//   Reset_n    in   asynchronous active-low reset
//   frame_clk  in   VGA vsync, asynchronous to Clk
//   keycode    in   current USB HID keycode (0x00 = no key)
//   BallX      out  ball centre X
//   BallY      out  ball centre Y
//   Ball_size  out  ball radius
//   frame_tick out  one-cycle pulse in DONE
//   busy       out  high in every state except IDLE
// ---------------------------------------------------------------------------
module ball_motion_ctrl
  import ball_pkg::*;
#(
  parameter int X_MIN    = BALL_X_MIN,
  parameter int X_MAX    = BALL_X_MAX,
  parameter int Y_MIN    = BALL_Y_MIN,
  parameter int Y_MAX    = BALL_Y_MAX,
  parameter int X_CENTER = BALL_X_CENTER,
  parameter int Y_CENTER = BALL_Y_CENTER,
  parameter int STEP     = BALL_STEP,
  parameter int SIZE_DEF = BALL_SIZE_DEF,
  parameter int SIZE_MIN = BALL_SIZE_MIN,
  parameter int SIZE_MAX = BALL_SIZE_MAX
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic [9:0] Ball_size,
  output logic       frame_tick,
  output logic       busy
);

  localparam logic signed [10:0] C_XMIN  = 11'(X_MIN);
  localparam logic signed [10:0] C_XMAX  = 11'(X_MAX);
  localparam logic signed [10:0] C_YMIN  = 11'(Y_MIN);
  localparam logic signed [10:0] C_YMAX  = 11'(Y_MAX);
  localparam logic signed [10:0] C_STEP  = 11'(STEP);
  localparam logic signed [10:0] C_STEPN = -C_STEP;
  localparam logic signed [10:0] C_ZERO  = 11'sd0;
  localparam logic [9:0]         C_XCEN  = 10'(X_CENTER);
  localparam logic [9:0]         C_YCEN  = 10'(Y_CENTER);
  localparam logic [9:0]         C_SDEF  = 10'(SIZE_DEF);
  localparam logic [9:0]         C_SMIN  = 10'(SIZE_MIN);
  localparam logic [9:0]         C_SMAX  = 10'(SIZE_MAX);

  state_t             r_state;
  logic               r_pending;
  logic [7:0]         r_prevKey;
  logic signed [10:0] r_motX;
  logic signed [10:0] r_motY;
  logic [9:0]         r_ballX;
  logic [9:0]         r_ballY;
  logic [9:0]         r_size;
  logic               r_frameTick;
  logic               r_busy;

  logic               w_frameEdge;
  logic signed [10:0] w_xS;
  logic signed [10:0] w_yS;
  logic signed [10:0] w_sizeS;
  logic signed [10:0] w_movX;
  logic signed [10:0] w_movY;
  axis_t              w_bndX;
  axis_t              w_bndY;

  edge_sync u_edgeSync (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .i_async (frame_clk),
    .o_rise  (w_frameEdge)
  );

  // Positions are widened to 11-bit signed so "pos - size" can go negative
  // near the top/left edges without wrapping.
  assign w_xS    = signed'({1'b0, r_ballX});
  assign w_yS    = signed'({1'b0, r_ballY});
  assign w_sizeS = signed'({1'b0, r_size});
  assign w_movX  = w_xS + r_motX;
  assign w_movY  = w_yS + r_motY;

  always_comb begin
    w_bndX = boundAxis(w_xS, w_sizeS, r_motX, C_XMIN, C_XMAX, C_STEP);
    w_bndY = boundAxis(w_yS, w_sizeS, r_motY, C_YMIN, C_YMAX, C_STEP);
  end

  // Frame sequencer. The keycode is consumed directly in SAMPLE; only the
  // previous code is kept so size keys step once per press. An edge that
  // arrives while an update is running is remembered in r_pending and
  // starts the next update as soon as the sequencer is back in IDLE.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= IDLE;
      r_pending   <= 1'b0;
      r_prevKey   <= 8'h00;
      r_motX      <= C_ZERO;
      r_motY      <= C_ZERO;
      r_ballX     <= C_XCEN;
      r_ballY     <= C_YCEN;
      r_size      <= C_SDEF;
      r_frameTick <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_frameTick <= 1'b0;
      if (w_frameEdge && (r_state != IDLE)) begin
        r_pending <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_frameEdge || r_pending) begin
            r_state   <= SAMPLE;
            r_pending <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        SAMPLE: begin
          r_state   <= MOVE;
          r_prevKey <= keycode;
          case (keycode)
            KEY_W: begin r_motX <= C_ZERO;  r_motY <= C_STEPN; end
            KEY_S: begin r_motX <= C_ZERO;  r_motY <= C_STEP;  end
            KEY_A: begin r_motX <= C_STEPN; r_motY <= C_ZERO;  end
            KEY_D: begin r_motX <= C_STEP;  r_motY <= C_ZERO;  end
            KEY_SPACE: begin
              r_ballX <= C_XCEN;
              r_ballY <= C_YCEN;
              r_motX  <= C_ZERO;
              r_motY  <= C_ZERO;
              r_state <= BOUND;
            end
            KEY_PLUS: begin
              if ((keycode != r_prevKey) && (r_size < C_SMAX)) begin
                r_size <= r_size + 10'd1;
              end
            end
            KEY_MINUS: begin
              if ((keycode != r_prevKey) && (r_size > C_SMIN)) begin
                r_size <= r_size - 10'd1;
              end
            end
            default: ;
          endcase
        end
        MOVE: begin
          r_ballX <= w_movX[9:0];
          r_ballY <= w_movY[9:0];
          r_state <= BOUND;
        end
        BOUND: begin
          r_ballX     <= w_bndX.pos[9:0];
          r_motX      <= w_bndX.mot;
          r_ballY     <= w_bndY.pos[9:0];
          r_motY      <= w_bndY.mot;
          r_frameTick <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign BallX      = r_ballX;
  assign BallY      = r_ballY;
  assign Ball_size  = r_size;
  assign frame_tick = r_frameTick;
  assign busy       = r_busy;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ball_motion_ctrl
// Directed and randomised frames for ball_motion_ctrl, checked against a
// frame-level integer model of the ball.
// ---------------------------------------------------------------------------
module tb_ball_motion_ctrl;

  logic       clock;
  logic       resetN;
  logic       frameClk;
  logic [7:0] keycode;
  logic [9:0] ballX;
  logic [9:0] ballY;
  logic [9:0] ballSize;
  logic       frameTick;
  logic       busy;

  int vectorCount = 0;
  int missCount   = 0;
  int tickCount   = 0;

  int mPosX, mPosY, mSize, mMotX, mMotY, mPrevKey;

  ball_motion_ctrl dut (
    .Clk        (clock),
    .Reset_n    (resetN),
    .frame_clk  (frameClk),
    .keycode    (keycode),
    .BallX      (ballX),
    .BallY      (ballY),
    .Ball_size  (ballSize),
    .frame_tick (frameTick),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count completed frame updates, sampled away from the active edge.
  always @(negedge clock) begin
    if (frameTick === 1'b1) tickCount++;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectorCount++;
    assert (observed === expected)
    else begin
      missCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mPosX = 320; mPosY = 240; mSize = 4; mMotX = 0; mMotY = 0; mPrevKey = 0;
  endtask

  // One frame of ball behaviour: steer, resize, move, then keep the ball
  // on screen, bouncing off whichever edges it touches.
  task automatic modelFrame(input int key);
    bit skipMove = 0;
    case (key)
      'h1A: begin mMotX = 0;  mMotY = -1; end
      'h16: begin mMotX = 0;  mMotY = 1;  end
      'h04: begin mMotX = -1; mMotY = 0;  end
      'h07: begin mMotX = 1;  mMotY = 0;  end
      'h2C: begin mPosX = 320; mPosY = 240; mMotX = 0; mMotY = 0; skipMove = 1; end
      default: ;
    endcase
    if (key != mPrevKey) begin
      if (key == 'h2E && mSize < 32) mSize = mSize + 1;
      if (key == 'h2D && mSize > 2)  mSize = mSize - 1;
    end
    mPrevKey = key;
    if (!skipMove) begin
      mPosX = mPosX + mMotX;
      mPosY = mPosY + mMotY;
    end
    if (mPosX + mSize >= 639)   begin mPosX = 639 - mSize; mMotX = -1; end
    else if (mPosX - mSize <= 0) begin mPosX = mSize;      mMotX = 1;  end
    if (mPosY + mSize >= 479)   begin mPosY = 479 - mSize; mMotY = -1; end
    else if (mPosY - mSize <= 0) begin mPosY = mSize;      mMotY = 1;  end
  endtask

  task automatic doReset();
    resetN   = 1'b0;
    frameClk = 1'b0;
    keycode  = 8'h00;
    repeat (3) @(negedge clock);
    resetN = 1'b1;
    modelReset();
    repeat (3) @(negedge clock);
  endtask

  // Runs one complete frame: raise vsync, wait for the update to finish,
  // then compare the ball against the model.
  task automatic applyStimulus(input logic [7:0] key);
    int cycles = 0;
    bit gotTick = 0;
    keycode = key;
    @(negedge clock);
    frameClk = 1'b1;
    while (!gotTick && cycles < 20) begin
      @(posedge clock);
      #1;
      cycles++;
      if (frameTick === 1'b1) gotTick = 1;
    end
    checkOutput("tick_seen", int'(gotTick), 1);
    checkOutput("tick_latency", int'(cycles >= 5 && cycles <= 7), 1);
    checkOutput("busy_in_done", int'(busy), 1);
    modelFrame(int'(key));
    checkOutput("ball_x", int'(ballX), mPosX);
    checkOutput("ball_y", int'(ballY), mPosY);
    checkOutput("ball_size", int'(ballSize), mSize);
    @(negedge clock);
    frameClk = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("busy_idle", int'(busy), 0);
  endtask

  logic [7:0] keyTable [8] = '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h2C, 8'h2E, 8'h2D, 8'h00};

  initial begin
    int ticksBefore;
    int maxY;
    int prevY;
    int guard;

    // Reset state
    doReset();
    checkOutput("reset_x", int'(ballX), 320);
    checkOutput("reset_y", int'(ballY), 240);
    checkOutput("reset_size", int'(ballSize), 4);
    checkOutput("reset_tick", int'(frameTick), 0);
    checkOutput("reset_busy", int'(busy), 0);

    // Steering right for ten frames
    ticksBefore = tickCount;
    for (int i = 0; i < 10; i++) applyStimulus(8'h07);
    checkOutput("steer_x", int'(ballX), 330);
    checkOutput("steer_y", int'(ballY), 240);
    checkOutput("steer_ticks", tickCount - ticksBefore, 10);

    // Bottom bounce
    doReset();
    maxY = 0;
    for (int i = 0; i < 240; i++) begin
      applyStimulus(8'h16);
      if (int'(ballY) > maxY) maxY = int'(ballY);
    end
    checkOutput("bounce_max_y", int'(maxY <= 475), 1);
    checkOutput("bounce_reached", maxY, 475);
    for (int i = 0; i < 3; i++) begin
      prevY = int'(ballY);
      applyStimulus(8'h00);
      checkOutput("bounce_decreasing", int'(int'(ballY) < prevY), 1);
    end

    // Size keys step once per press and saturate
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(8'h2E);
    checkOutput("size_hold", int'(ballSize), 5);
    applyStimulus(8'h00);
    applyStimulus(8'h2E);
    checkOutput("size_repress", int'(ballSize), 6);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(8'h2D);
      applyStimulus(8'h00);
    end
    checkOutput("size_floor", int'(ballSize), 2);

    // Right-edge clamp on growth, then recentre
    doReset();
    applyStimulus(8'h2D);
    guard = 0;
    while (mPosX != 636 && guard < 400) begin
      applyStimulus(8'h07);
      guard++;
    end
    checkOutput("clamp_setup_x", int'(ballX), 636);
    applyStimulus(8'h2E);
    checkOutput("clamp_x", int'(ballX), 635);
    checkOutput("clamp_size", int'(ballSize), 4);
    applyStimulus(8'h00);
    checkOutput("clamp_bounce_x", int'(ballX), 634);
    applyStimulus(8'h2C);
    checkOutput("space_x", int'(ballX), 320);
    checkOutput("space_y", int'(ballY), 240);
    applyStimulus(8'h00);
    checkOutput("space_still_x", int'(ballX), 320);
    checkOutput("space_still_y", int'(ballY), 240);

    // Randomised key sequence against the model
    doReset();
    for (int i = 0; i < 200; i++) begin
      int pick = int'($urandom_range(0, 8));
      logic [7:0] key;
      key = (pick == 8) ? 8'($urandom_range(0, 255)) : keyTable[pick];
      applyStimulus(key);
    end

    // Asynchronous reset in the middle of an update
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(8'h07);
    keycode = 8'h07;
    @(negedge clock);
    frameClk = 1'b1;
    repeat (4) begin
      @(posedge clock);
      #1;
    end
    checkOutput("midframe_busy", int'(busy), 1);
    resetN   = 1'b0;
    frameClk = 1'b0;
    #1;
    checkOutput("abort_x", int'(ballX), 320);
    checkOutput("abort_y", int'(ballY), 240);
    checkOutput("abort_size", int'(ballSize), 4);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_tick", int'(frameTick), 0);
    repeat (2) @(negedge clock);
    resetN = 1'b1;
    modelReset();
    ticksBefore = tickCount;
    repeat (10) @(negedge clock);
    checkOutput("abort_no_update", tickCount - ticksBefore, 0);
    checkOutput("abort_hold_x", int'(ballX), 320);

    // Two vsync edges two clocks apart give exactly two updates
    keycode = 8'h07;
    ticksBefore = tickCount;
    @(negedge clock);
    frameClk = 1'b1;
    @(negedge clock);
    frameClk = 1'b0;
    @(negedge clock);
    frameClk = 1'b1;
    repeat (40) @(negedge clock);
    checkOutput("pending_ticks", tickCount - ticksBefore, 2);
    modelFrame(8'h07);
    modelFrame(8'h07);
    checkOutput("pending_x", int'(ballX), mPosX);
    checkOutput("pending_y", int'(ballY), mPosY);
    checkOutput("pending_busy", int'(busy), 0);
    frameClk = 1'b0;
    repeat (5) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
